// File: rtl/fetch_ctrl.sv
// Instruction fetch sequencer: owns the architectural PC, fetches one word per
// instruction, hands it to decode, waits for retire and traps bad targets/errors.
module fetch_ctrl #(
    parameter int               XLEN     = 32,
    parameter logic [XLEN-1:0]  RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rstl,
    output logic [XLEN-1:0]   pc,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [XLEN-1:0]   imem_addr,
    input  logic              imem_rsp_valid,
    input  logic              imem_rsp_err,
    input  logic [31:0]       imem_rdata,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [31:0]       inst,
    input  logic              retire,
    input  logic [XLEN-1:0]   next_pc,
    output logic              fault,
    output logic [1:0]        fault_cause,
    output logic [XLEN-1:0]   fault_pc,
    output logic [63:0]       instret
);

    localparam logic [1:0] CAUSE_ACCESS    = 2'b01;
    localparam logic [1:0] CAUSE_MISALIGN  = 2'b10;

    typedef enum logic [2:0] {
        ST_REQ,
        ST_WAIT,
        ST_ISSUE,
        ST_EXEC,
        ST_FAULT
    } state_t;

    state_t state;

    assign imem_addr = pc;

    // imem_req_valid doubles as the "out of reset" bit: REQ only raises it on the
    // first edge after rstl releases, so no request is visible during reset.
    always_ff @(posedge clk or negedge rstl) begin
        if (!rstl) begin
            state          <= ST_REQ;
            pc             <= RESET_PC;
            inst           <= '0;
            imem_req_valid <= 1'b0;
            inst_valid     <= 1'b0;
            fault          <= 1'b0;
            fault_cause    <= '0;
            fault_pc       <= '0;
            instret        <= '0;
        end else begin
            case (state)
                ST_REQ: begin
                    if (!imem_req_valid) begin
                        imem_req_valid <= 1'b1;
                    end else if (imem_req_ready) begin
                        imem_req_valid <= 1'b0;
                        state          <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (imem_rsp_valid) begin
                        if (imem_rsp_err) begin
                            fault       <= 1'b1;
                            fault_cause <= CAUSE_ACCESS;
                            fault_pc    <= pc;
                            state       <= ST_FAULT;
                        end else begin
                            inst       <= imem_rdata;
                            inst_valid <= 1'b1;
                            state      <= ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (inst_ready) begin
                        inst_valid <= 1'b0;
                        state      <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (retire) begin
                        // A misaligned target leaves pc and instret untouched.
                        if (next_pc[1:0] != 2'b00) begin
                            fault       <= 1'b1;
                            fault_cause <= CAUSE_MISALIGN;
                            fault_pc    <= next_pc;
                            state       <= ST_FAULT;
                        end else begin
                            pc             <= next_pc;
                            instret        <= instret + 64'd1;
                            imem_req_valid <= 1'b1;
                            state          <= ST_REQ;
                        end
                    end
                end
                ST_FAULT: begin
                    imem_req_valid <= 1'b0;
                    inst_valid     <= 1'b0;
                end
                default: begin
                    state <= ST_FAULT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed scenarios plus a randomized
// instruction stream compared against a PC/instret reference model.
module tb_fetch_ctrl;

    localparam int XLEN = 32;

    logic              clk = 1'b0;
    logic              rstl = 1'b0;
    logic [XLEN-1:0]   pc;
    logic              imem_req_valid;
    logic              imem_req_ready = 1'b0;
    logic [XLEN-1:0]   imem_addr;
    logic              imem_rsp_valid = 1'b0;
    logic              imem_rsp_err = 1'b0;
    logic [31:0]       imem_rdata = '0;
    logic              inst_valid;
    logic              inst_ready = 1'b0;
    logic [31:0]       inst;
    logic              retire = 1'b0;
    logic [XLEN-1:0]   next_pc = '0;
    logic              fault;
    logic [1:0]        fault_cause;
    logic [XLEN-1:0]   fault_pc;
    logic [63:0]       instret;

    int tests = 0;
    int fails = 0;

    logic [XLEN-1:0] model_pc;
    logic [63:0]     model_instret;

    fetch_ctrl #(.XLEN(XLEN), .RESET_PC('0)) dut (
        .clk(clk),
        .rstl(rstl),
        .pc(pc),
        .imem_req_valid(imem_req_valid),
        .imem_req_ready(imem_req_ready),
        .imem_addr(imem_addr),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_err(imem_rsp_err),
        .imem_rdata(imem_rdata),
        .inst_valid(inst_valid),
        .inst_ready(inst_ready),
        .inst(inst),
        .retire(retire),
        .next_pc(next_pc),
        .fault(fault),
        .fault_cause(fault_cause),
        .fault_pc(fault_pc),
        .instret(instret)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstl = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_err = 1'b0;
        inst_ready = 1'b0;
        retire = 1'b0;
        #1;
        step();
        step();
        rstl = 1'b1;
        step();
        model_pc = '0;
        model_instret = '0;
    endtask

    // Plays memory, decode and execute for one instruction; records observations only.
    task automatic run_instr(input logic [31:0] word, input logic [XLEN-1:0] npc,
                             input int rdly, input int rspdly, input int idly, input int edly,
                             output bit ok, output logic [XLEN-1:0] seen_addr,
                             output bit addr_stable, output logic [31:0] seen_inst,
                             output bit inst_stable);
        int n;
        ok = 1'b0;
        addr_stable = 1'b1;
        inst_stable = 1'b1;
        seen_addr = '0;
        seen_inst = '0;
        n = 0;
        while (!imem_req_valid && n < 20) begin
            step();
            n++;
        end
        if (!imem_req_valid) return;
        seen_addr = imem_addr;
        for (int i = 0; i < rdly; i++) begin
            step();
            if (!imem_req_valid || imem_addr !== seen_addr) addr_stable = 1'b0;
        end
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        for (int i = 0; i < rspdly; i++) step();
        imem_rsp_valid = 1'b1;
        imem_rdata = word;
        step();
        imem_rsp_valid = 1'b0;
        imem_rdata = $urandom;
        if (!inst_valid) return;
        seen_inst = inst;
        for (int i = 0; i < idly; i++) begin
            step();
            if (!inst_valid || inst !== seen_inst) inst_stable = 1'b0;
        end
        inst_ready = 1'b1;
        step();
        inst_ready = 1'b0;
        for (int i = 0; i < edly; i++) step();
        retire = 1'b1;
        next_pc = npc;
        step();
        retire = 1'b0;
        ok = 1'b1;
    endtask

    task automatic test_reset();
        rstl = 1'b0;
        #1;
        step();
        tests++;
        if (pc !== 32'h0 || imem_req_valid !== 1'b0 || inst_valid !== 1'b0 ||
            fault !== 1'b0 || instret !== 64'd0 || fault_cause !== 2'b00 || fault_pc !== 32'h0) begin
            fails++;
            $display("[TB] FAIL reset_state: pc=%h rv=%b iv=%b fault=%b instret=%0d cause=%b fpc=%h, want all zero",
                     pc, imem_req_valid, inst_valid, fault, instret, fault_cause, fault_pc);
        end
        rstl = 1'b1;
        #1;
        tests++;
        if (imem_req_valid !== 1'b0) begin
            fails++;
            $display("[TB] FAIL req_before_edge: req_valid=%b, want 0", imem_req_valid);
        end
        step();
        tests++;
        if (imem_req_valid !== 1'b1 || imem_addr !== 32'h0) begin
            fails++;
            $display("[TB] FAIL first_request: req_valid=%b addr=%h, want 1/00000000", imem_req_valid, imem_addr);
        end
    endtask

    task automatic test_basic_fetch();
        bit ok, as, is;
        logic [XLEN-1:0] a;
        logic [31:0] w;
        run_instr(32'h0000_0013, 32'h4, 3, 0, 2, 1, ok, a, as, w, is);
        tests++;
        if (!ok || a !== 32'h0 || !as) begin
            fails++;
            $display("[TB] FAIL basic_request: ok=%b addr=%h stable=%b, want 1/00000000/1", ok, a, as);
        end
        tests++;
        if (w !== 32'h13 || !is) begin
            fails++;
            $display("[TB] FAIL basic_inst: inst=%h stable=%b, want 00000013/1", w, is);
        end
        tests++;
        if (imem_req_valid !== 1'b1 || imem_addr !== 32'h4 || instret !== 64'd1) begin
            fails++;
            $display("[TB] FAIL basic_retire: rv=%b addr=%h instret=%0d, want 1/00000004/1",
                     imem_req_valid, imem_addr, instret);
        end
    endtask

    task automatic test_redirect();
        bit ok, as, is;
        logic [XLEN-1:0] a;
        logic [31:0] w;
        run_instr(32'h0800_006F, 32'h80, 0, 1, 0, 0, ok, a, as, w, is);
        tests++;
        if (!ok || a !== 32'h4 || imem_addr !== 32'h80 || instret !== 64'd2 || imem_req_valid !== 1'b1) begin
            fails++;
            $display("[TB] FAIL redirect_80: ok=%b from=%h addr=%h instret=%0d, want 1/00000004/00000080/2",
                     ok, a, imem_addr, instret);
        end
        run_instr(32'hFE00_0EE3, 32'h7C, 1, 0, 1, 2, ok, a, as, w, is);
        tests++;
        if (!ok || a !== 32'h80 || imem_addr !== 32'h7C || instret !== 64'd3 || imem_req_valid !== 1'b1) begin
            fails++;
            $display("[TB] FAIL redirect_7c: ok=%b from=%h addr=%h instret=%0d, want 1/00000080/0000007c/3",
                     ok, a, imem_addr, instret);
        end
    endtask

    task automatic test_retire_ignored();
        retire = 1'b1;
        next_pc = 32'h200;
        imem_rsp_valid = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        step();
        retire = 1'b0;
        imem_rsp_valid = 1'b0;
        step();
        tests++;
        if (pc !== 32'h7C || instret !== 64'd3 || imem_req_valid !== 1'b1 || inst_valid !== 1'b0) begin
            fails++;
            $display("[TB] FAIL retire_in_req: pc=%h instret=%0d rv=%b iv=%b, want 0000007c/3/1/0",
                     pc, instret, imem_req_valid, inst_valid);
        end
    endtask

    task automatic test_misaligned();
        bit ok, as, is;
        logic [XLEN-1:0] a;
        logic [31:0] w;
        int seen_valid;
        run_instr(32'h0000_0067, 32'h102, 0, 0, 0, 0, ok, a, as, w, is);
        tests++;
        if (!ok || fault !== 1'b1 || fault_cause !== 2'b10 || fault_pc !== 32'h102) begin
            fails++;
            $display("[TB] FAIL misalign_fault: ok=%b fault=%b cause=%b fpc=%h, want 1/1/10/00000102",
                     ok, fault, fault_cause, fault_pc);
        end
        tests++;
        if (pc !== 32'h7C || instret !== 64'd3) begin
            fails++;
            $display("[TB] FAIL misalign_pc: pc=%h instret=%0d, want 0000007c/3", pc, instret);
        end
        seen_valid = 0;
        for (int i = 0; i < 20; i++) begin
            imem_req_ready = 1'($urandom);
            imem_rsp_valid = 1'($urandom);
            inst_ready = 1'($urandom);
            retire = 1'($urandom);
            next_pc = $urandom & 32'hFFFF_FFFC;
            step();
            if (imem_req_valid || inst_valid) seen_valid++;
        end
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        inst_ready = 1'b0;
        retire = 1'b0;
        tests++;
        if (seen_valid != 0 || fault !== 1'b1 || pc !== 32'h7C) begin
            fails++;
            $display("[TB] FAIL misalign_sticky: valid_cycles=%0d fault=%b pc=%h, want 0/1/0000007c",
                     seen_valid, fault, pc);
        end
    endtask

    task automatic test_access_error();
        bit ok, as, is;
        logic [XLEN-1:0] a;
        logic [31:0] w;
        int seen_valid;
        do_reset();
        run_instr(32'h13, 32'h4, 0, 0, 0, 0, ok, a, as, w, is);
        run_instr(32'h13, 32'h8, 0, 0, 0, 0, ok, a, as, w, is);
        tests++;
        if (!ok || imem_req_valid !== 1'b1 || imem_addr !== 32'h8) begin
            fails++;
            $display("[TB] FAIL err_setup: ok=%b rv=%b addr=%h, want 1/1/00000008", ok, imem_req_valid, imem_addr);
        end
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_err = 1'b1;
        step();
        imem_rsp_valid = 1'b0;
        imem_rsp_err = 1'b0;
        seen_valid = inst_valid ? 1 : 0;
        tests++;
        if (fault !== 1'b1 || fault_cause !== 2'b01 || fault_pc !== 32'h8) begin
            fails++;
            $display("[TB] FAIL access_fault: fault=%b cause=%b fpc=%h, want 1/01/00000008", fault, fault_cause, fault_pc);
        end
        for (int i = 0; i < 10; i++) begin
            inst_ready = 1'($urandom);
            imem_rsp_valid = 1'($urandom);
            step();
            if (inst_valid || imem_req_valid) seen_valid++;
        end
        inst_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        tests++;
        if (seen_valid != 0) begin
            fails++;
            $display("[TB] FAIL access_no_issue: valid_cycles=%0d, want 0", seen_valid);
        end
    endtask

    task automatic test_async_reset();
        bit ok, as, is;
        logic [XLEN-1:0] a;
        logic [31:0] w;
        do_reset();
        run_instr(32'h13, 32'h40, 0, 0, 0, 0, ok, a, as, w, is);
        // Mid-REQ: request is up at 0x40 when reset drops between edges.
        #2 rstl = 1'b0;
        #1;
        tests++;
        if (imem_req_valid !== 1'b0 || pc !== 32'h0 || instret !== 64'd0) begin
            fails++;
            $display("[TB] FAIL async_req: rv=%b pc=%h instret=%0d, want 0/00000000/0", imem_req_valid, pc, instret);
        end
        #1 rstl = 1'b1;
        step();
        // Mid-WAIT
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        #2 rstl = 1'b0;
        #1;
        tests++;
        if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0 || pc !== 32'h0) begin
            fails++;
            $display("[TB] FAIL async_wait: rv=%b iv=%b pc=%h, want 0/0/00000000", imem_req_valid, inst_valid, pc);
        end
        #1 rstl = 1'b1;
        step();
        tests++;
        if (imem_req_valid !== 1'b1 || imem_addr !== 32'h0) begin
            fails++;
            $display("[TB] FAIL async_restart1: rv=%b addr=%h, want 1/00000000", imem_req_valid, imem_addr);
        end
        // Mid-ISSUE
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rdata = 32'h1234_5678;
        step();
        imem_rsp_valid = 1'b0;
        #2 rstl = 1'b0;
        #1;
        tests++;
        if (inst_valid !== 1'b0 || imem_req_valid !== 1'b0 || inst !== 32'h0 || pc !== 32'h0) begin
            fails++;
            $display("[TB] FAIL async_issue: iv=%b rv=%b inst=%h pc=%h, want 0/0/00000000/00000000",
                     inst_valid, imem_req_valid, inst, pc);
        end
        #1 rstl = 1'b1;
        step();
        tests++;
        if (imem_req_valid !== 1'b1 || imem_addr !== 32'h0 || fault !== 1'b0) begin
            fails++;
            $display("[TB] FAIL async_restart2: rv=%b addr=%h fault=%b, want 1/00000000/0", imem_req_valid, imem_addr, fault);
        end
    endtask

    task automatic test_random();
        bit ok, as, is;
        logic [XLEN-1:0] a, npc;
        logic [31:0] w, word;
        do_reset();
        for (int k = 0; k < 40; k++) begin
            word = $urandom;
            npc = $urandom & 32'hFFFF_FFFC;
            run_instr(word, npc, $urandom_range(0, 3), $urandom_range(0, 3),
                      $urandom_range(0, 3), $urandom_range(0, 3), ok, a, as, w, is);
            model_pc = npc;
            model_instret = model_instret + 64'd1;
            tests++;
            if (!ok || !as || !is || w !== word) begin
                fails++;
                $display("[TB] FAIL rand_fetch[%0d]: ok=%b addr_stable=%b inst_stable=%b inst=%h, want 1/1/1/%h",
                         k, ok, as, is, w, word);
            end
            tests++;
            if (imem_req_valid !== 1'b1 || imem_addr !== model_pc || instret !== model_instret) begin
                fails++;
                $display("[TB] FAIL rand_retire[%0d]: rv=%b addr=%h instret=%0d, want 1/%h/%0d",
                         k, imem_req_valid, imem_addr, instret, model_pc, model_instret);
            end
        end
        npc = ($urandom & 32'hFFFF_FFFC) | 32'(1 + $urandom_range(0, 2));
        run_instr(32'h13, npc, 0, 1, 1, 1, ok, a, as, w, is);
        tests++;
        if (!ok || a !== model_pc || fault !== 1'b1 || fault_cause !== 2'b10 || fault_pc !== npc ||
            pc !== model_pc || instret !== model_instret) begin
            fails++;
            $display("[TB] FAIL rand_misalign: ok=%b fault=%b cause=%b fpc=%h pc=%h instret=%0d, want 1/1/10/%h/%h/%0d",
                     ok, fault, fault_cause, fault_pc, pc, instret, npc, model_pc, model_instret);
        end
    endtask

    initial begin
        test_reset();
        test_basic_fetch();
        test_redirect();
        test_retire_ignored();
        test_misaligned();
        test_access_error();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
